mod_mult_arbiter: RTL

//  Shares one modular multiplier (Clk/Reset/a/b/product/Done; Reset high parks it, low runs it)

---
 rtl/mod_mult_arbiter_if.sv | 30 +++
 rtl/mod_mult_arbiter.sv | 128 ++++++++++++
 2 files changed

// File: rtl/mod_mult_arbiter_if.sv
// Bundle of requester and multiplier-side signals for the shared modular multiplier arbiter.
// The slave modport is the arbiter view; master is the surrounding environment.
interface mod_mult_arbiter_if #(
  parameter int WIDTH = 256
);
  logic [1:0]       req;
  logic [WIDTH-1:0] a0;
  logic [WIDTH-1:0] b0;
  logic [WIDTH-1:0] a1;
  logic [WIDTH-1:0] b1;
  logic [1:0]       gnt;
  logic [1:0]       done;
  logic [WIDTH-1:0] result;
  logic             timeout;
  logic             mult_reset;
  logic [WIDTH-1:0] mult_a;
  logic [WIDTH-1:0] mult_b;
  logic             mult_done;
  logic [WIDTH-1:0] mult_product;

  modport slave (
    input  req, a0, b0, a1, b1, mult_done, mult_product,
    output gnt, done, result, timeout, mult_reset, mult_a, mult_b
  );

  modport master (
    output req, a0, b0, a1, b1, mult_done, mult_product,
    input  gnt, done, result, timeout, mult_reset, mult_a, mult_b
  );
endinterface

// File: rtl/mod_mult_arbiter.sv
// Round-robin arbiter sharing one modular multiplier between two requesters, with
// operand capture, start/park sequencing, result return and a RUN-cycle watchdog.
module mod_mult_arbiter #(
  parameter int WIDTH      = 256,
  parameter int MAX_CYCLES = 1024
) (
  input  logic                Clk,
  input  logic                Reset_n,
  mod_mult_arbiter_if.slave   bus
);

  localparam int CW = $clog2(MAX_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    RESP = 2'd3
  } state_t;

  state_t           state_q,      state_d;
  logic [1:0]       gnt_q,        gnt_d;
  logic [1:0]       done_q,       done_d;
  logic             timeout_q,    timeout_d;
  logic [WIDTH-1:0] result_q,     result_d;
  logic [WIDTH-1:0] mult_a_q,     mult_a_d;
  logic [WIDTH-1:0] mult_b_q,     mult_b_d;
  logic             mult_reset_q, mult_reset_d;
  logic [CW-1:0]    count_q,      count_d;
  logic             last_gnt_q,   last_gnt_d;
  logic             pick_s;

  // State register and all registered outputs
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q      <= IDLE;
      gnt_q        <= 2'b00;
      done_q       <= 2'b00;
      timeout_q    <= 1'b0;
      result_q     <= '0;
      mult_a_q     <= '0;
      mult_b_q     <= '0;
      mult_reset_q <= 1'b1;
      count_q      <= '0;
      last_gnt_q   <= 1'b1;
    end else begin
      state_q      <= state_d;
      gnt_q        <= gnt_d;
      done_q       <= done_d;
      timeout_q    <= timeout_d;
      result_q     <= result_d;
      mult_a_q     <= mult_a_d;
      mult_b_q     <= mult_b_d;
      mult_reset_q <= mult_reset_d;
      count_q      <= count_d;
      last_gnt_q   <= last_gnt_d;
    end
  end

  // Next-state and output logic; done/timeout default low so they pulse for RESP only
  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    done_d     = 2'b00;
    timeout_d  = 1'b0;
    result_d   = result_q;
    mult_a_d   = mult_a_q;
    mult_b_d   = mult_b_q;
    count_d    = count_q;
    last_gnt_d = last_gnt_q;
    pick_s     = (bus.req == 2'b11) ? ~last_gnt_q : bus.req[1];

    case (state_q)
      IDLE: begin
        if (bus.req != 2'b00) begin
          state_d    = LOAD;
          gnt_d      = pick_s ? 2'b10 : 2'b01;
          last_gnt_d = pick_s;
          mult_a_d   = pick_s ? bus.a1 : bus.a0;
          mult_b_d   = pick_s ? bus.b1 : bus.b0;
          count_d    = '0;
        end else begin
          gnt_d = 2'b00;
        end
      end
      LOAD: begin
        state_d = RUN;
        count_d = '0;
      end
      RUN: begin
        // A Done seen in the first RUN cycle may be left over from the previous op
        if (bus.mult_done && (count_q != '0)) begin
          state_d            = RESP;
          gnt_d              = 2'b00;
          done_d[last_gnt_q] = 1'b1;
          result_d           = bus.mult_product;
          timeout_d          = 1'b0;
        end else if (count_q == CW'(MAX_CYCLES - 1)) begin
          state_d            = RESP;
          gnt_d              = 2'b00;
          done_d[last_gnt_q] = 1'b1;
          result_d           = '0;
          timeout_d          = 1'b1;
        end else begin
          count_d = count_q + CW'(1);
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        gnt_d   = 2'b00;
      end
    endcase

    mult_reset_d = (state_d != RUN);
  end

  assign bus.gnt        = gnt_q;
  assign bus.done       = done_q;
  assign bus.timeout    = timeout_q;
  assign bus.result     = result_q;
  assign bus.mult_a     = mult_a_q;
  assign bus.mult_b     = mult_b_q;
  assign bus.mult_reset = mult_reset_q;

endmodule
